mem_request_arbiter: RTL and testbench
======================================

// Module: mem_request_arbiter
// PURPOSE
// - Memory-side counterpart to the pipeline stall/flush logic. Turns the datapath's instruction and data requests into single RAM transactions.
// - Returns the ihit/dhit pulses that gate the IF/ID..MEM/WB register enables and the EX/MEM flush.
// - Sits between the pipeline datapath and the single-ported RAM model. Data requests have priority over instruction fetch.
// PARAMETERS
// - TIMEOUT_CYCLES  255  max cycles one RAM access may stay un-ACCESSed before mem_err is set
// - CNT_W           32   width of performance counters (MEM_PERF_CNT_EN only)
// PORTS
// - CLK          in   1      clock; everything is on the rising edge
// - nRST         in   1      asynchronous, active-low reset
// - iREN         in   1      instruction fetch request
// - iaddr        in   32     fetch address (word_t)
// - ihit         out  1      one-cycle pulse: iload valid
// - iload        out  32     fetched instruction (registered)
// - dREN         in   1      data read request
// - dWEN         in   1      data write request
// - daddr        in   32     data address
// - dstore       in   32     write data
// - dhit         out  1      one-cycle pulse: data access complete
// - dload        out  32     read data (registered)
// - ramREN       out  1      RAM read strobe
// - ramWEN       out  1      RAM write strobe
// - ramaddr      out  32     RAM address
// - ramstore     out  32     RAM write data
// - ramload      in   32     RAM read data
// - ramstate     in   2      ramstate_t: FREE, BUSY, ACCESS, ERROR
// - mem_err      out  1      sticky: timeout occurred; cleared only by reset
// BEHAVIOUR
// - Reset: state=IDLE, timer=0. All outputs 0: ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err.
// - States: IDLE, DATA, INSTR, RESP. Address, store data and op are latched on leaving IDLE; RAM outputs drive from the latches.
// - IDLE:
//   - (dREN|dWEN) -> DATA.
//   - else iREN -> INSTR.
//   - RAM strobes are 0 in IDLE.
// - DATA:
//   - Drives ramWEN=latched dWEN, ramREN=latched dREN & ~dWEN. Write wins if both are set.
//   - ramstate==ACCESS: dload<=ramload (reads only), dhit<=1 next cycle, -> RESP.
//   - Read abort: dREN drops before ACCESS (flush) -> IDLE with no hit.
//   - Writes never abort.
// - INSTR:
//   - Drives ramREN=1.
//   - ACCESS: iload<=ramload, ihit<=1 next cycle, -> RESP.
//   - Abort: iREN drops, or iaddr != latched address (PC redirect) -> IDLE with no hit. Re-arbitration starts the following cycle.
// - RESP:
//   - Hit pulse is high for exactly this cycle. Strobes are 0 and requests are ignored.
//   - Next cycle -> IDLE. This gives the pipeline one edge to advance and update its requests.
// - Latency: request seen in IDLE at cycle 0; strobes from cycle 1; ACCESS in cycle k; hit in cycle k+1. Minimum is 3 cycles.
// - BUSY/FREE: hold the state and strobes.
// - ERROR: re-issue the same access (hold), with no hit.
// - Timer: counts cycles in DATA/INSTR and clears on state change. Reaching TIMEOUT_CYCLES sets mem_err=1 and forces IDLE, with no hit.
// - Simultaneous iREN and dREN: data is served first, then instruction after RESP->IDLE. ihit and dhit are never high together.
// - Reset mid-transaction: strobes drop immediately (asynchronous reset). A partial write is not retried.
// CONFIGURATION
// - MEM_PERF_CNT_EN defined:
//   - Adds outputs icount, dcount and stall_cycles, each [CNT_W-1:0].
//   - Counters count ihit pulses, dhit pulses, and cycles where a request is pending without a hit. They wrap at 2^CNT_W and reset to 0.
// - Undefined: these ports and their logic are absent. Behaviour is otherwise identical.
// STRUCTURE
// - word_t and ramstate_t come from cpu_types_pkg.
// - Add arb_state_t (IDLE, DATA, INSTR, RESP) to cpu_types_pkg.
// - Sub-module mem_perf_counter (enable-pulse counter, width CNT_W). Instantiated 3x, under MEM_PERF_CNT_EN only.
// TESTING
// - Read, RAM latency 2 cycles: dREN=1, daddr=0x40, ramload=0xDEADBEEF -> dhit for 1 cycle at cycle 4, dload=0xDEADBEEF.
// - iREN and dWEN both set from cycle 0 (daddr=0x80, dstore=0x12345678) -> ramWEN first, dhit. Then RESP, IDLE, ramREN for iaddr. ihit later, never overlapping dhit.
// - iaddr changes 0x100->0x200 while in INSTR with ramstate=BUSY -> no ihit. Next fetch drives ramaddr=0x200.
// - ramstate stuck BUSY, TIMEOUT_CYCLES=8 -> mem_err=1 after 8 cycles in DATA, state IDLE, no dhit. mem_err stays set until nRST.
// - nRST asserted while ramWEN=1 -> all outputs 0 in the same cycle. After release, the first request behaves as in the first test.
// - MEM_PERF_CNT_EN with 3 fetches, 2 loads and a 1-cycle RAM -> icount=3, dcount=2. stall_cycles equals summed pending cycles.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state and memory arbiter states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_perf_counter.sv
// Wrapping event counter for memory performance monitoring.
// Only compiled when MEM_PERF_CNT_EN is defined.
`ifdef MEM_PERF_CNT_EN
module mem_perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/mem_request_arbiter.sv
// Arbitrates pipeline instruction/data requests onto a single-ported RAM, data first.
// Optional performance counters are enabled by defining MEM_PERF_CNT_EN.
module mem_request_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  word_t       addr_q, addr_d;
  word_t       store_q, store_d;
  logic        wen_q, wen_d;
  word_t       iload_q, iload_d;
  word_t       dload_q, dload_d;
  logic        ihit_q, ihit_d;
  logic        dhit_q, dhit_d;
  logic        err_q, err_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      store_q <= '0;
      wen_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wen_q   <= wen_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      err_q   <= err_d;
    end
  end

  // Aborts take precedence over a coinciding ACCESS so flushed/redirected data is never
  // returned; ACCESS in the final allowed cycle still completes instead of timing out.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    addr_d  = addr_q;
    store_d = store_q;
    wen_d   = wen_q;
    iload_d = iload_q;
    dload_d = dload_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          state_d = DATA;
          addr_d  = daddr;
          store_d = dstore;
          wen_d   = dWEN;
        end else if (iREN) begin
          state_d = INSTR;
          addr_d  = iaddr;
          wen_d   = 1'b0;
        end
      end
      DATA: begin
        if (!wen_q && !dREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          if (!wen_q) dload_d = ramload;
          dhit_d  = 1'b1;
          state_d = RESP;
        end else if (timer_q == TLIMIT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      INSTR: begin
        if (!iREN || (iaddr != addr_q)) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          iload_d = ramload;
          ihit_d  = 1'b1;
          state_d = RESP;
        end else if (timer_q == TLIMIT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  assign ramWEN   = (state_q == DATA) && wen_q;
  assign ramREN   = (state_q == INSTR) || ((state_q == DATA) && !wen_q);
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign mem_err  = err_q;

`ifdef MEM_PERF_CNT_EN
  logic stall_en;
  assign stall_en = (iREN || dREN || dWEN) && !(ihit_q || dhit_q);

  mem_perf_counter #(.W(CNT_W)) u_icount (
    .CLK(CLK), .nRST(nRST), .en_i(ihit_q), .count_o(icount)
  );
  mem_perf_counter #(.W(CNT_W)) u_dcount (
    .CLK(CLK), .nRST(nRST), .en_i(dhit_q), .count_o(dcount)
  );
  mem_perf_counter #(.W(CNT_W)) u_stall (
    .CLK(CLK), .nRST(nRST), .en_i(stall_en), .count_o(stall_cycles)
  );
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Self-checking bench for mem_request_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model. Counter checks under MEM_PERF_CNT_EN.
module tb_mem_request_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_PERF_CNT_EN
  logic [CW-1:0] icount, dcount, stall_cycles;
`endif

  always #5 CLK = ~CLK;

  mem_request_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
`ifdef MEM_PERF_CNT_EN
    , .icount(icount), .dcount(dcount), .stall_cycles(stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction (kind 0 none, 1 data, 2 instr)
  // and a pending hit to report (0 none, 1 data, 2 instr).
  int          mKind, mResp, mAge;
  bit          mWrite, mErr;
  logic [31:0] mAddr, mStore, mIload, mDload;
  int          mIcnt, mDcnt, mStall;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mKind = 0; mResp = 0; mAge = 0; mWrite = 0; mErr = 0;
    mAddr = '0; mStore = '0; mIload = '0; mDload = '0;
    mIcnt = 0; mDcnt = 0; mStall = 0;
  endtask

  task automatic drive(bit ir, logic [31:0] ia, bit dr, bit dw, logic [31:0] da,
                       logic [31:0] ds, logic [1:0] rs, logic [31:0] rl);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
  endtask

  // One clock cycle: check outputs mid-low-phase, advance the model, wait for next negedge.
  task automatic step();
    bit eI, eD, eR, eW, aborted;
    #1;
    eI = (mResp == 2);
    eD = (mResp == 1);
    eW = (mKind == 1) && mWrite;
    eR = (mKind == 2) || ((mKind == 1) && !mWrite);
    chk("ihit", ihit, eI);
    chk("dhit", dhit, eD);
    chk("hit_overlap", ihit & dhit, 0);
    chk("ramREN", ramREN, eR);
    chk("ramWEN", ramWEN, eW);
    chk("mem_err", mem_err, mErr);
    chk("iload", iload, mIload);
    chk("dload", dload, mDload);
    if (eR || eW) chk("ramaddr", ramaddr, mAddr);
    if (eW) chk("ramstore", ramstore, mStore);
`ifdef MEM_PERF_CNT_EN
    chk("icount", icount, CW'(mIcnt));
    chk("dcount", dcount, CW'(mDcnt));
    chk("stall_cycles", stall_cycles, CW'(mStall));
    mIcnt += int'(eI);
    mDcnt += int'(eD);
    if ((iREN || dREN || dWEN) && !(eI || eD)) mStall++;
`endif
    aborted = ((mKind == 1) && !mWrite && !dREN) ||
              ((mKind == 2) && (!iREN || (iaddr != mAddr)));
    if (mResp != 0) begin
      mResp = 0;
    end else if (mKind == 0) begin
      if (dREN || dWEN) begin
        mKind = 1; mWrite = dWEN; mAddr = daddr; mStore = dstore; mAge = 0;
      end else if (iREN) begin
        mKind = 2; mWrite = 0; mAddr = iaddr; mAge = 0;
      end
    end else if (aborted) begin
      mKind = 0;
    end else if (ramstate == ACCESS) begin
      if (mKind == 2) mIload = ramload;
      else if (!mWrite) mDload = ramload;
      mResp = mKind;
      mKind = 0;
    end else begin
      mAge++;
      if (mAge >= TO) begin
        mErr = 1;
        mKind = 0;
      end
    end
    @(negedge CLK);
  endtask

  task automatic doReset();
    nRST = 1'b0;
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    #1;
    chk("rst_ihit", ihit, 0);
    chk("rst_dhit", dhit, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_mem_err", mem_err, 0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    modelReset();
  endtask

  task automatic readTest();
    drive(0, '0, 1, 0, 32'h40, '0, BUSY, '0);
    repeat (3) step();
    drive(0, '0, 1, 0, 32'h40, '0, ACCESS, 32'hDEADBEEF);
    step();
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    #1;
    chk("t1_dhit_c4", dhit, 1);
    chk("t1_dload", dload, 32'hDEADBEEF);
    step();
    step();
    chk("t1_dhit_gone", dhit, 0);
  endtask

  initial begin
    logic [31:0] ia, da, ds;
    bit          ir, dr, dw;
    int          sel;
    logic [1:0]  rs;

    modelReset();
    doReset();

    // Plain read with two BUSY cycles before ACCESS.
    readTest();

    // Simultaneous write and fetch: data goes first, fetch follows after RESP.
    drive(1, 32'h300, 0, 1, 32'h80, 32'h12345678, ACCESS, '0);
    step();
    #1;
    chk("t2_ramWEN_first", ramWEN, 1);
    chk("t2_ramREN_first", ramREN, 0);
    chk("t2_waddr", ramaddr, 32'h80);
    step();
    drive(1, 32'h300, 0, 0, '0, '0, ACCESS, '0);
    #1;
    chk("t2_dhit", dhit, 1);
    step();
    step();
    drive(1, 32'h300, 0, 0, '0, '0, ACCESS, 32'hCAFEF00D);
    #1;
    chk("t2_fetch_addr", ramaddr, 32'h300);
    step();
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    #1;
    chk("t2_ihit", ihit, 1);
    chk("t2_iload", iload, 32'hCAFEF00D);
    step();

    // PC redirect while BUSY aborts the fetch; the new address is fetched next.
    drive(1, 32'h100, 0, 0, '0, '0, BUSY, '0);
    step();
    step();
    drive(1, 32'h200, 0, 0, '0, '0, BUSY, '0);
    step();
    #1;
    chk("t3_no_strobe_idle", ramREN, 0);
    chk("t3_no_ihit", ihit, 0);
    step();
    drive(1, 32'h200, 0, 0, '0, '0, ACCESS, 32'h0BADF00D);
    #1;
    chk("t3_redirect_addr", ramaddr, 32'h200);
    step();
    drive(0, '0, 0, 0, '0, '0, FREE, '0);
    #1;
    chk("t3_ihit", ihit, 1);
    step();

    // RAM stuck BUSY: timeout after TO cycles in DATA, sticky error.
    doReset();
    drive(0, '0, 1, 0, 32'h44, '0, BUSY, '0);
    repeat (TO + 1) step();
    drive(0, '0, 0, 0, '0, '0, BUSY, '0);
    #1;
    chk("t4_mem_err", mem_err, 1);
    chk("t4_idle_strobe", ramREN, 0);
    chk("t4_no_dhit", dhit, 0);
    repeat (6) step();
    chk("t4_err_sticky", mem_err, 1);

    // Reset in the middle of a write drops every output immediately.
    drive(0, '0, 0, 1, 32'h90, 32'hA5A5A5A5, BUSY, '0);
    step();
    #2;
    chk("t5_ramWEN_before", ramWEN, 1);
    doReset();
    readTest();

    // Random traffic against the model, with one reset in the middle.
    ia = 32'h100; ir = 1; dr = 0; dw = 0; da = '0; ds = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) doReset();
      if ($urandom_range(9) == 0) ia = 32'h100 + ($urandom_range(15) << 2);
      if ($urandom_range(4) == 0) ir = ($urandom_range(3) != 0);
      if ($urandom_range(3) == 0) begin
        sel = $urandom_range(5);
        dr = (sel == 0) || (sel == 1);
        dw = (sel == 2) || ((sel == 3) && ($urandom_range(1) == 0));
        da = $urandom & 32'h0000_0FFC;
        ds = $urandom;
      end
      sel = $urandom_range(9);
      rs = (sel < 4) ? ACCESS : (sel < 8) ? BUSY : (sel == 8) ? FREE : ERROR;
      drive(ir, ia, dr, dw, da, ds, rs, $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
